// File: rtl/encode_div_60s_21s_40_seq_if.sv
// Handshake and data bundle for the encode-path signed divider.
//   master: drives ce/start/din0/din1, observes busy/done/dout/rem/dbz/ovf.
//   slave : the divider side of the same bundle.
interface encode_div_60s_21s_40_seq_if #(
  parameter int din0_WIDTH = 60,
  parameter int din1_WIDTH = 21,
  parameter int dout_WIDTH = 40
);
  logic                         ce;
  logic                         start;
  logic signed [din0_WIDTH-1:0] din0;
  logic signed [din1_WIDTH-1:0] din1;
  logic                         busy;
  logic                         done;
  logic signed [dout_WIDTH-1:0] dout;
  logic signed [din1_WIDTH-1:0] rem;
  logic                         dbz;
  logic                         ovf;

  modport master (
    output ce, start, din0, din1,
    input  busy, done, dout, rem, dbz, ovf
  );

  modport slave (
    input  ce, start, din0, din1,
    output busy, done, dout, rem, dbz, ovf
  );
endinterface

// File: rtl/encode_div_60s_21s_40_seq.sv
// Iterative radix-2 restoring signed divider (truncating toward zero).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave side of the handshake/data interface: ce, start, din0, din1 in;
//           busy, done, dout (saturating quotient), rem, dbz, ovf out
module encode_div_60s_21s_40_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 60,
  parameter int din1_WIDTH = 21,
  parameter int dout_WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  encode_div_60s_21s_40_seq_if.slave   bus
);

  if (ID < 0) begin : g_id_chk
    $error("ID must be non-negative");
  end

  localparam int CntW = $clog2(din0_WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(din0_WIDTH - 1);
  // Largest positive quotient magnitude representable in dout.
  localparam logic [din0_WIDTH-1:0] MaxMag =
    {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                  r_state;
  logic [CntW-1:0]         r_cnt;
  logic [din0_WIDTH-1:0]   r_dvd;     // dividend magnitude, shifts out as quotient shifts in
  logic [din1_WIDTH-1:0]   r_div;     // divisor magnitude
  logic [din1_WIDTH-1:0]   r_prem;    // partial remainder magnitude
  logic                    r_sign_q;
  logic                    r_sign_r;
  logic                    r_dbz_pend;
  logic                    r_busy;
  logic                    r_done;
  logic [dout_WIDTH-1:0]   r_dout;
  logic [din1_WIDTH-1:0]   r_rem;
  logic                    r_dbz;
  logic                    r_ovf;

  logic [din0_WIDTH-1:0]   w_din0_mag;
  logic [din1_WIDTH-1:0]   w_din1_mag;
  logic                    w_din1_zero;
  logic [din1_WIDTH:0]     w_shift;
  logic                    w_ge;
  logic [din1_WIDTH-1:0]   w_prem_nxt;
  logic [dout_WIDTH-1:0]   w_q_neg;
  logic                    w_q_ovf;
  logic [dout_WIDTH-1:0]   w_q_val;
  logic [dout_WIDTH-1:0]   w_q_sat;
  logic [din1_WIDTH-1:0]   w_rem_val;

  always_comb begin
    // -2^59 negates to 2^59, which still fits as an unsigned 60-bit magnitude.
    w_din0_mag  = bus.din0[din0_WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;
    w_din1_mag  = bus.din1[din1_WIDTH-1] ? (~bus.din1 + 1'b1) : bus.din1;
    w_din1_zero = (bus.din1 == '0);

    w_shift    = {r_prem, r_dvd[din0_WIDTH-1]};
    w_ge       = (w_shift >= {1'b0, r_div});
    // When w_ge the difference is below the divisor, so the low bits are exact.
    w_prem_nxt = w_ge ? (w_shift[din1_WIDTH-1:0] - r_div) : w_shift[din1_WIDTH-1:0];

    w_q_neg   = ~r_dvd[dout_WIDTH-1:0] + 1'b1;
    w_q_ovf   = r_sign_q ? (r_dvd > MaxMag + 1'b1) : (r_dvd > MaxMag);
    w_q_sat   = r_sign_q ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
    w_q_val   = r_sign_q ? w_q_neg : r_dvd[dout_WIDTH-1:0];
    w_rem_val = r_sign_r ? (~r_prem + 1'b1) : r_prem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_div      <= '0;
      r_prem     <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dout     <= '0;
      r_rem      <= '0;
      r_dbz      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (bus.ce) begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state    <= StCalc;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_dvd      <= w_din0_mag;
            r_div      <= w_din1_mag;
            // Zero divisor: park the truncated dividend here; it becomes rem.
            r_prem     <= w_din1_zero ? bus.din0[din1_WIDTH-1:0] : '0;
            r_sign_q   <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
            r_sign_r   <= bus.din0[din0_WIDTH-1];
            r_dbz_pend <= w_din1_zero;
          end
        end
        StCalc: begin
          // A zero divisor spends this one cycle without stepping, so done
          // lands two enabled edges after start.
          if (r_dbz_pend) begin
            r_state <= StFix;
          end else begin
            r_prem <= w_prem_nxt;
            r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LastStep) r_state <= StFix;
          end
        end
        StFix: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_dbz   <= r_dbz_pend;
          if (r_dbz_pend) begin
            r_dout <= r_sign_r ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                               : {1'b0, {(dout_WIDTH-1){1'b1}}};
            r_rem  <= r_prem;
            r_ovf  <= 1'b0;
          end else begin
            r_dout <= w_q_ovf ? w_q_sat : w_q_val;
            r_rem  <= w_rem_val;
            r_ovf  <= w_q_ovf;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dout = r_dout;
  assign bus.rem  = r_rem;
  assign bus.dbz  = r_dbz;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_encode_div_60s_21s_40_seq.sv
// Directed bench for the encode-path signed divider: reset state, sign cases,
// saturation, divide-by-zero, handshake, clock-enable stall and mid-run reset.
module tb_encode_div_60s_21s_40_seq;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n;
  int   seen;

  localparam logic signed [63:0] QMax = 64'sh7F_FFFF_FFFF;
  localparam logic signed [63:0] QMin = -64'sh80_0000_0000;

  encode_div_60s_21s_40_seq_if #(
    .din0_WIDTH(60), .din1_WIDTH(21), .dout_WIDTH(40)
  ) bus ();

  encode_div_60s_21s_40_seq #(
    .ID(1), .din0_WIDTH(60), .din1_WIDTH(21), .dout_WIDTH(40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents start for one clock; returns #1 after the accepting edge.
  task automatic start_div(input logic signed [59:0] a, input logic signed [20:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.din0  = a;
    bus.din1  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.din0  = 60'sh123_4567_89AB_CDEF;
    bus.din1  = 21'sh0_5555;
  endtask

  // Counts edges until done is seen, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!bus.done && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  task automatic check_res(input string tag, input logic signed [63:0] q,
                           input logic signed [63:0] r, input logic o, input logic z);
    chk({tag, "_dout"}, bus.dout, q);
    chk({tag, "_rem"},  bus.rem,  r);
    chk({tag, "_ovf"},  bus.ovf,  o);
    chk({tag, "_dbz"},  bus.dbz,  z);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_rem",  bus.rem,  0);
    chk("rst_dbz",  bus.dbz,  0);
    chk("rst_ovf",  bus.ovf,  0);
    @(negedge clk);
    reset = 1'b1;

    // Basic 1000/7 with latency and busy
    start_div(60'sd1000, 21'sd7);
    chk("basic_busy", bus.busy, 1);
    wait_done(n);
    chk("basic_lat", n, 61);
    chk("basic_busy_done", bus.busy, 0);
    check_res("basic", 142, 6, 0, 0);
    @(posedge clk);
    #1;
    chk("basic_done_pulse", bus.done, 0);
    chk("basic_hold_dout", bus.dout, 142);

    // Sign combinations
    start_div(-60'sd1000, 21'sd7);
    wait_done(n);
    check_res("neg_pos", -142, -6, 0, 0);
    start_div(60'sd1000, -21'sd7);
    wait_done(n);
    check_res("pos_neg", -142, 6, 0, 0);
    start_div(-60'sd1000, -21'sd7);
    wait_done(n);
    check_res("neg_neg", 142, -6, 0, 0);

    // Saturation
    start_div(60'sh7FF_FFFF_FFFF_FFFF, 21'sd1);
    wait_done(n);
    check_res("ovf_max", QMax, 0, 1, 0);
    start_div(60'sh800_0000_0000_0000, -21'sd1);
    wait_done(n);
    check_res("ovf_minneg", QMax, 0, 1, 0);
    start_div(60'sh800_0000_0000_0000, 21'sd1);
    wait_done(n);
    check_res("ovf_min", QMin, 0, 1, 0);

    // Divisor -2^20
    start_div(60'sd3145733, 21'sh10_0000);
    wait_done(n);
    check_res("div_min", -3, 5, 0, 0);

    // Divide by zero
    start_div(-60'sd5, 21'sd0);
    wait_done(n);
    chk("dbz_neg_lat", n, 2);
    check_res("dbz_neg", QMin, -5, 0, 1);
    start_div(60'sd0, 21'sd0);
    wait_done(n);
    check_res("dbz_zero", QMax, 0, 0, 1);

    // Second start while busy is ignored
    start_div(60'sd1000, 21'sd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.din0  = 60'sd50;
    bus.din1  = 21'sd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n);
    chk("busy_ign_lat", n, 55);
    check_res("busy_ign", 142, 6, 0, 0);

    // Start on the done cycle is accepted
    bus.start = 1'b1;
    bus.din0  = -60'sd1000;
    bus.din1  = -21'sd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_done", bus.done, 0);
    wait_done(n);
    chk("b2b_lat", n, 61);
    check_res("b2b", 142, -6, 0, 0);

    // Clock-enable stall of 10 cycles mid-CALC
    start_div(60'sd1000, 21'sd7);
    repeat (20) @(posedge clk);
    #1;
    bus.ce = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.ce = 1'b1;
    wait_done(n);
    chk("stall_lat", n + 30, 71);
    check_res("stall", 142, 6, 0, 0);

    // Reset mid-CALC aborts
    start_div(60'sd77, 21'sd3);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_dout", bus.dout, 0);
    chk("mid_rst_rem",  bus.rem,  0);
    chk("mid_rst_ovf",  bus.ovf,  0);
    #2;
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    start_div(60'sd1000, 21'sd7);
    wait_done(n);
    chk("after_rst_lat", n, 61);
    check_res("after_rst", 142, 6, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
